// File: rtl/m_mc_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32 subset,
// with sticky illegal-opcode trap and cycle/retire performance counters.
module m_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic [31:0]      w_ir,
  input  logic             w_imem_ack,
  input  logic             w_dmem_ack,
  input  logic             w_br_taken,
  output logic             w_imem_req,
  output logic             w_ir_we,
  output logic             w_pc_we,
  output logic [1:0]       w_pc_sel,
  output logic             w_rf_we,
  output logic [1:0]       w_wb_sel,
  output logic             w_alusrc_b,
  output logic             w_dmem_req,
  output logic             w_dmem_we,
  output logic             w_trap,
  output logic [2:0]       r_state,
  output logic [CNT_W-1:0] r_cyc_cnt,
  output logic [CNT_W-1:0] r_ret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI
  } cls_t;

  state_t state_q;
  cls_t   cls_q;
  cls_t   ir_cls;
  logic   rd_nz_q;
  logic   retire;

  // Only opcode and rd are consumed here; the rest of the IR belongs to the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^w_ir[31:12];

  assign r_state = state_q;

  always_comb begin
    case (w_ir[6:0])
      7'b0110011: ir_cls = C_OP;
      7'b0010011: ir_cls = C_OPIMM;
      7'b0000011: ir_cls = C_LOAD;
      7'b0100011: ir_cls = C_STORE;
      7'b1100011: ir_cls = C_BRANCH;
      7'b1101111: ir_cls = C_JAL;
      7'b0110111: ir_cls = C_LUI;
      default:    ir_cls = C_NONE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 2'd0;
    w_rf_we    = 1'b0;
    w_wb_sel   = 2'd0;
    w_alusrc_b = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_trap     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_we    = w_imem_ack;
      end
      S_EXEC: begin
        w_alusrc_b = cls_q inside {C_OPIMM, C_LOAD, C_STORE};
        if (cls_q == C_BRANCH) begin
          w_pc_we  = 1'b1;
          w_pc_sel = w_br_taken ? 2'd1 : 2'd0;
          retire   = 1'b1;
        end else if (cls_q == C_JAL) begin
          w_pc_we  = 1'b1;
          w_pc_sel = 2'd2;
          w_rf_we  = rd_nz_q;
          w_wb_sel = 2'd2;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (cls_q == C_STORE);
        if (cls_q == C_STORE && w_dmem_ack) begin
          w_pc_we = 1'b1;
          retire  = 1'b1;
        end
      end
      S_WB: begin
        w_rf_we  = rd_nz_q;
        w_pc_we  = 1'b1;
        retire   = 1'b1;
        w_wb_sel = (cls_q == C_LOAD) ? 2'd1 : (cls_q == C_LUI) ? 2'd3 : 2'd0;
      end
      S_TRAP:  w_trap = 1'b1;
      default: ;
    endcase
    // Reset masks every enable regardless of the state it is about to leave.
    if (w_rst) begin
      w_imem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_pc_sel   = 2'd0;
      w_rf_we    = 1'b0;
      w_wb_sel   = 2'd0;
      w_alusrc_b = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_trap     = 1'b0;
      retire     = 1'b0;
    end
  end

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      rd_nz_q   <= 1'b0;
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      if (retire) r_ret_cnt <= r_ret_cnt + CNT_W'(1);
      case (state_q)
        S_FETCH: if (w_imem_ack) state_q <= S_DECODE;
        S_DECODE: begin
          cls_q   <= ir_cls;
          rd_nz_q <= |w_ir[11:7];
          state_q <= (ir_cls == C_NONE) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          case (cls_q)
            C_OP, C_OPIMM, C_LUI: state_q <= S_WB;
            C_LOAD, C_STORE:      state_q <= S_MEM;
            default:              state_q <= S_FETCH;
          endcase
        end
        S_MEM:   if (w_dmem_ack) state_q <= (cls_q == C_STORE) ? S_FETCH : S_WB;
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
